// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: opcode values and the
// fetch FSM state encoding.
package fetch_pkg;

  localparam int unsigned OP_LDAC  = 7;
  localparam int unsigned OP_STAC  = 11;
  localparam int unsigned OP_MVACR = 15;
  localparam int unsigned OP_MVR   = 16;
  localparam int unsigned OP_ADD   = 17;
  localparam int unsigned OP_ADDM  = 19;
  localparam int unsigned OP_INAC  = 23;
  localparam int unsigned OP_SUB   = 24;
  localparam int unsigned OP_MUL   = 26;
  localparam int unsigned OP_MULM  = 28;
  localparam int unsigned OP_CLAC  = 32;
  localparam int unsigned OP_JUMP  = 33;
  localparam int unsigned OP_JPNZ  = 35;
  localparam int unsigned OP_ENDOP = 40;
  localparam int unsigned OP_NOP   = 41;
  localparam int unsigned OP_MVB   = 42;
  localparam int unsigned OP_MVC   = 43;
  localparam int unsigned OP_MVACC = 44;
  localparam int unsigned OP_LDA   = 45;
  localparam int unsigned OP_LDB   = 51;
  localparam int unsigned OP_LDC   = 57;
  localparam int unsigned OP_STC   = 63;

  // Encoding kept as plain vectors so older tools and dumps read the same values.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH_OP = 3'd1;
  localparam logic [2:0] ST_WAIT_OP  = 3'd2;
  localparam logic [2:0] ST_WAIT_ARG = 3'd3;
  localparam logic [2:0] ST_PRESENT  = 3'd4;
  localparam logic [2:0] ST_HALTED   = 3'd5;

endpackage

// File: rtl/instr_len_decode.sv
// Instruction length decode: flags opcodes that carry an operand word.
// The core decoder instantiates this too, so both sides agree on length.
module instr_len_decode
  import fetch_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] opcode,
  output logic              two_word
);

  always_comb begin
    two_word = 1'b0;
    case (opcode)
      DATA_W'(OP_LDAC),
      DATA_W'(OP_STAC),
      DATA_W'(OP_JUMP),
      DATA_W'(OP_JPNZ),
      DATA_W'(OP_LDA),
      DATA_W'(OP_LDB),
      DATA_W'(OP_LDC),
      DATA_W'(OP_STC):  two_word = 1'b1;
      default:          two_word = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads opcode (and operand) words from a synchronous
// instruction RAM and presents them to the core over a valid/ready handshake.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [DATA_W-1:0] iram_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              busy,
  output logic              halted
);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] opcode_reg, opcode_next;
  logic [DATA_W-1:0] operand_reg, operand_next;
  logic [ADDR_W-1:0] bundle_pc_reg, bundle_pc_next;
  logic              two_word_reg, two_word_next;
  logic              data_two_word;

  // Length is decided on the raw RAM word in WAIT_OP, then remembered for the
  // pc increment at handshake time.
  instr_len_decode #(
    .DATA_W (DATA_W)
  ) u_len_decode (
    .opcode   (iram_data),
    .two_word (data_two_word)
  );

  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_HALTED);
  assign halted      = (state_reg == ST_HALTED);
  assign instr_valid = (state_reg == ST_PRESENT);

  assign instr_opcode  = opcode_reg;
  assign instr_operand = operand_reg;
  assign instr_pc      = bundle_pc_reg;

  // The operand read is issued speculatively while the opcode is still in flight.
  assign iram_addr = (state_reg == ST_WAIT_OP) ? pc_reg + ADDR_W'(1) : pc_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    opcode_next    = opcode_reg;
    operand_next   = operand_reg;
    bundle_pc_next = bundle_pc_reg;
    two_word_next  = two_word_reg;

    case (state_reg)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_next    = RESET_PC;
          state_next = ST_FETCH_OP;
        end
      end
      ST_FETCH_OP: begin
        state_next = ST_WAIT_OP;
      end
      ST_WAIT_OP: begin
        opcode_next    = iram_data;
        bundle_pc_next = pc_reg;
        two_word_next  = data_two_word;
        if (data_two_word) begin
          state_next = ST_WAIT_ARG;
        end else begin
          operand_next = '0;
          state_next   = ST_PRESENT;
        end
      end
      ST_WAIT_ARG: begin
        operand_next = iram_data;
        state_next   = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (instr_ready) begin
          if (opcode_reg == DATA_W'(OP_ENDOP)) begin
            state_next = ST_HALTED;
          end else begin
            pc_next    = pc_reg + (two_word_reg ? ADDR_W'(2) : ADDR_W'(1));
            state_next = ST_FETCH_OP;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Redirect overrides everything above, including a same-cycle handshake;
    // any half-captured bundle is thrown away by keeping the old registers.
    if (redirect && busy) begin
      pc_next        = redirect_addr;
      state_next     = ST_FETCH_OP;
      opcode_next    = opcode_reg;
      operand_next   = operand_reg;
      bundle_pc_next = bundle_pc_reg;
      two_word_next  = two_word_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= RESET_PC;
      opcode_reg    <= '0;
      operand_reg   <= '0;
      bundle_pc_reg <= '0;
      two_word_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      opcode_reg    <= opcode_next;
      operand_reg   <= operand_next;
      bundle_pc_reg <= bundle_pc_next;
      two_word_reg  <= two_word_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: length table, directed corner
// sequences and a randomized run against a bundle-level program model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, start, instr_ready, redirect;
  logic [15:0] iram_addr, iram_data, redirect_addr;
  logic        instr_valid, busy, halted;
  logic [15:0] instr_opcode, instr_operand, instr_pc;

  logic [15:0] mem [0:65535];
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] op;
    logic [15:0] arg;
    logic [15:0] exp_operand;
    int          exp_lat;
    logic [15:0] exp_next;
    logic        exp_halt;
  } vec_t;

  vec_t vecs [14];
  logic [15:0] op_list [22] = '{16'd41, 16'd7, 16'd11, 16'd15, 16'd16, 16'd17, 16'd19, 16'd23,
                                16'd24, 16'd26, 16'd28, 16'd32, 16'd33, 16'd35, 16'd40, 16'd45,
                                16'd51, 16'd57, 16'd42, 16'd43, 16'd44, 16'd63};
  logic [15:0] t1_pc [3]  = '{16'd0, 16'd1, 16'd3};
  logic [15:0] t1_op [3]  = '{16'd32, 16'd11, 16'd40};
  logic [15:0] t1_arg [3] = '{16'd0, 16'd6, 16'd0};
  int          t1_lat [3] = '{2, 3, 2};

  always #5 clk = ~clk;

  always @(posedge clk) iram_data <= mem[iram_addr];

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .iram_addr     (iram_addr),
    .iram_data     (iram_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_pc      (instr_pc),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .busy          (busy),
    .halted        (halted)
  );

  function automatic logic is_two(input logic [15:0] op);
    return op inside {16'd7, 16'd11, 16'd33, 16'd35, 16'd45, 16'd51, 16'd57, 16'd63};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; redirect = 1'b0; instr_ready = 1'b0; redirect_addr = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic check_bundle(input string tag, input logic [15:0] pc,
                              input logic [15:0] op, input logic [15:0] arg);
    check({tag, "_valid"}, instr_valid, 1'b1);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_op"}, instr_opcode, op);
    check({tag, "_arg"}, instr_operand, arg);
  endtask

  initial begin
    int lat;
    int gap, nb;
    logic seen, exp_halt;
    logic [15:0] exp_pc, ap, cur_op;

    rst = 1'b1; start = 1'b0; redirect = 1'b0; instr_ready = 1'b0; redirect_addr = '0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;

    vecs[0]  = '{16'd32,    16'd11, 16'd0,  2, 16'd1, 1'b0};
    vecs[1]  = '{16'd11,    16'd6,  16'd6,  3, 16'd2, 1'b0};
    vecs[2]  = '{16'd7,     16'd9,  16'd9,  3, 16'd2, 1'b0};
    vecs[3]  = '{16'd33,    16'd20, 16'd20, 3, 16'd2, 1'b0};
    vecs[4]  = '{16'd35,    16'd1,  16'd1,  3, 16'd2, 1'b0};
    vecs[5]  = '{16'd45,    16'd2,  16'd2,  3, 16'd2, 1'b0};
    vecs[6]  = '{16'd51,    16'd3,  16'd3,  3, 16'd2, 1'b0};
    vecs[7]  = '{16'd57,    16'd4,  16'd4,  3, 16'd2, 1'b0};
    vecs[8]  = '{16'd63,    16'd5,  16'd5,  3, 16'd2, 1'b0};
    vecs[9]  = '{16'd40,    16'd5,  16'd0,  2, 16'd0, 1'b1};
    vecs[10] = '{16'd41,    16'd7,  16'd0,  2, 16'd1, 1'b0};
    vecs[11] = '{16'd8,     16'd3,  16'd0,  2, 16'd1, 1'b0};
    vecs[12] = '{16'd62,    16'd4,  16'd0,  2, 16'd1, 1'b0};
    vecs[13] = '{16'hFFFF,  16'd9,  16'd0,  2, 16'd1, 1'b0};

    // Reset state
    do_reset();
    check("rst_valid", instr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_op", instr_opcode, 16'd0);
    check("rst_arg", instr_operand, 16'd0);
    check("rst_pc", instr_pc, 16'd0);
    check("rst_addr", iram_addr, 16'd0);

    // Single-instruction table: length, latency and next pc
    foreach (vecs[v]) begin
      do_reset();
      mem[0] = vecs[v].op;
      mem[1] = vecs[v].arg;
      pulse_start();
      wait_valid(lat);
      check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      check_bundle($sformatf("vec%0d", v), 16'd0, vecs[v].op, vecs[v].exp_operand);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      check($sformatf("vec%0d_halt", v), halted, vecs[v].exp_halt);
      check($sformatf("vec%0d_next", v), iram_addr, vecs[v].exp_next);
    end

    // Program {32,11,6,40} with ready held high
    do_reset();
    mem[0] = 16'd32; mem[1] = 16'd11; mem[2] = 16'd6; mem[3] = 16'd40;
    pulse_start();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(lat);
      check($sformatf("prog_lat%0d", k), lat, t1_lat[k]);
      check_bundle($sformatf("prog%0d", k), t1_pc[k], t1_op[k], t1_arg[k]);
      step();
    end
    instr_ready = 1'b0;
    check("prog_halted", halted, 1'b1);
    check("prog_busy", busy, 1'b0);

    // Same program, STAC bundle stalled for 5 cycles (start pulsed mid-stall)
    do_reset();
    pulse_start();
    wait_valid(lat);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      check_bundle($sformatf("stall%0d", k), 16'd1, 16'd11, 16'd6);
      check($sformatf("stall%0d_addr", k), iram_addr <= 16'd2, 1'b1);
      step();
    end
    start = 1'b0;
    check_bundle("stall_end", 16'd1, 16'd11, 16'd6);
    instr_ready = 1'b1;
    step();
    wait_valid(lat);
    check_bundle("stall_endop", 16'd3, 16'd40, 16'd0);
    step();
    instr_ready = 1'b0;
    check("stall_halted", halted, 1'b1);

    // Taken jump: redirect at the JUMP handshake
    do_reset();
    mem[0] = 16'd33; mem[1] = 16'd20; mem[20] = 16'd40;
    pulse_start();
    wait_valid(lat);
    check_bundle("jump", 16'd0, 16'd33, 16'd20);
    instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 16'd20;
    step();
    redirect = 1'b0;
    check("jump_valid_drop", instr_valid, 1'b0);
    check("jump_addr", iram_addr, 16'd20);
    wait_valid(lat);
    check_bundle("jump_tgt", 16'd20, 16'd40, 16'd0);
    step();
    instr_ready = 1'b0;
    check("jump_halted", halted, 1'b1);

    // Redirect while waiting for the operand word
    do_reset();
    mem[0] = 16'd7; mem[1] = 16'd5; mem[30] = 16'd41;
    pulse_start();
    step();
    step();
    check("warg_busy", busy, 1'b1);
    check("warg_valid", instr_valid, 1'b0);
    redirect = 1'b1; redirect_addr = 16'd30;
    step();
    redirect = 1'b0;
    check("warg_valid_after", instr_valid, 1'b0);
    check("warg_addr", iram_addr, 16'd30);
    wait_valid(lat);
    check("warg_lat", lat, 2);
    check_bundle("warg_tgt", 16'd30, 16'd41, 16'd0);

    // Two-word instruction straddling the top of the address space
    do_reset();
    mem[16'hFFFF] = 16'd7; mem[0] = 16'd9; mem[1] = 16'd41;
    pulse_start();
    redirect = 1'b1; redirect_addr = 16'hFFFF;
    step();
    redirect = 1'b0;
    check("wrap_addr", iram_addr, 16'hFFFF);
    wait_valid(lat);
    check("wrap_lat", lat, 3);
    check_bundle("wrap", 16'hFFFF, 16'd7, 16'd9);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("wrap_next", iram_addr, 16'd1);

    // Reset in WAIT_OP, then halt and restart
    do_reset();
    mem[0] = 16'd32; mem[1] = 16'd40;
    pulse_start();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_addr", iram_addr, 16'd0);
    check("midrst_op", instr_opcode, 16'd0);
    pulse_start();
    instr_ready = 1'b1;
    wait_valid(lat);
    check_bundle("midrst_b0", 16'd0, 16'd32, 16'd0);
    step();
    wait_valid(lat);
    check_bundle("midrst_b1", 16'd1, 16'd40, 16'd0);
    step();
    instr_ready = 1'b0;
    check("midrst_halted", halted, 1'b1);
    pulse_start();
    check("restart_busy", busy, 1'b1);
    check("restart_addr", iram_addr, 16'd0);
    wait_valid(lat);
    check_bundle("restart", 16'd0, 16'd32, 16'd0);

    // Randomized program with random stalls and redirects
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 3) != 0) ? op_list[$urandom_range(0, 21)] : 16'($urandom);
    do_reset();
    pulse_start();
    exp_pc = 16'd0; exp_halt = 1'b0; gap = 0; seen = 1'b0; nb = 0;
    for (int cyc = 0; cyc < 20000 && nb < 300; cyc++) begin
      if (halted) begin
        check("rand_halt_expected", exp_halt, 1'b1);
        start = 1'b1;
        exp_pc = 16'd0; exp_halt = 1'b0; gap = 0; seen = 1'b0;
      end else if (instr_valid) begin
        cur_op = mem[exp_pc];
        if (!seen) begin
          ap = exp_pc + 16'd1;
          check("rand_unexpected_bundle", exp_halt, 1'b0);
          check("rand_gap", gap, is_two(cur_op) ? 3 : 2);
          check_bundle("rand", exp_pc, cur_op, is_two(cur_op) ? mem[ap] : 16'd0);
          seen = 1'b1;
          nb++;
        end
        instr_ready = ($urandom_range(0, 2) != 0);
        redirect = ($urandom_range(0, 7) == 0);
        redirect_addr = ($urandom_range(0, 9) == 0) ? 16'(16'hFFFF - $urandom_range(0, 1))
                                                     : 16'($urandom_range(0, 255));
        if (redirect) begin
          exp_pc = redirect_addr; seen = 1'b0; gap = 0;
        end else if (instr_ready) begin
          if (cur_op == 16'd40) exp_halt = 1'b1;
          else exp_pc = exp_pc + (is_two(cur_op) ? 16'd2 : 16'd1);
          seen = 1'b0; gap = 0;
        end
      end else begin
        gap++;
      end
      step();
      start = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    end
    check("rand_progress", nb >= 300, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
